seg7_scan_decoder: RTL
======================

Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the 8-digit multiplexed 7-segment display driver.
- Watches the `segments`/`anodes` bus the driver produces and decodes each digit's pattern back to a hex nibble.
- Once all eight digits have been captured, presents the reconstructed 32-bit word.
- Used as an on-chip loopback checker and as a self-checking monitor in display benches.

Parameters:
- SETTLE_CYCLES, 4, consecutive cycles a registered anode/segment pair must be unchanged before it is captured (legal range 1..255).
- DIGITS, 8, number of multiplexed digits; the word width is 4*DIGITS.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- segments  input  7  segment lines, active-low; bit0=a, bit1=b … bit6=g.
- anodes  input  8  digit enables, active-low; anodes[i]=0 selects digit i, which carries word bits [4i+3:4i].
- hex_out  output  32  last complete reconstructed word.
- hex_valid  output  1  one-cycle pulse when hex_out has been updated.
- digit_mask  output  8  digits captured in the current frame.
- seg_err  output  1  one-cycle pulse: a settled pattern is not one of the 16 hex glyphs.
- anode_err  output  1  one-cycle pulse: a settled anode value has more than one bit low.

Behaviour:
- Reset (reset=0 at a clock edge) clears:
  - hex_out=0, hex_valid=0, digit_mask=0, seg_err=0, anode_err=0;
  - the input registers, the digit registers and the settle counter;
  - the capture-done flag.
- Reset applied mid-frame discards every partially captured digit.
- Input stage: `segments` and `anodes` are registered once (seg_q, an_q). All further logic uses the registered values.
- Settle counter:
  - Loads 0 when {an_q, seg_q} differs from its previous-cycle value; this also clears the capture-done flag.
  - Otherwise increments, saturating at SETTLE_CYCLES-1.
- Capture event: the counter equals SETTLE_CYCLES-1 and capture-done=0. At a capture event, capture-done is set, so exactly one capture occurs per dwell.
- Capture classes:
  - Blank (an_q=8'hFF): no action, no error.
  - Single low anode i with a valid glyph: digit register i is written with the nibble and digit_mask[i] is set. Recapturing a digit already in the mask overwrites its register and keeps the mask bit.
  - Single low anode with an invalid glyph: seg_err pulses on the next cycle; the register and the mask are unchanged.
  - Two or more low anodes: anode_err pulses on the next cycle; nothing is written. seg_err is not evaluated in this case.
- Glyph decode (active-low seg_q to nibble):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5;
  - 02→6, 78→7, 00→8, 10→9, 08→A, 03→b;
  - 46→C, 21→d, 06→E, 0E→F.
  - All other 112 codes are invalid.
- Frame completion:
  - The first cycle digit_mask==8'hFF, hex_out is loaded with the concatenated digit registers (digit 7 in the MSBs).
  - hex_valid is high for exactly that cycle.
  - digit_mask returns to 0 on the same edge.
  - Digit registers are not cleared.
- Latency: a settled digit is captured SETTLE_CYCLES+1 cycles after it first appears on the pins. hex_valid rises 1 cycle after the eighth capture.
- Capture order is irrelevant; any scan order or direction completes a frame.
- hex_out holds its value between frames.
- SETTLE_CYCLES=1 captures every new registered value on its first cycle.

Test Plan:
- Reset value: hold reset=0 for 3 cycles with arbitrary inputs → hex_out=0, hex_valid=0, digit_mask=0, no error pulses.
- Loopback: the display driver is fed HEX_in=32'h12345678 and scans 0→7 → after one full scan, hex_out=32'h12345678 and hex_valid pulses once per complete scan.
- Dwell shorter than the settle window: with SETTLE_CYCLES=4, drive anodes=8'hFE, segments=7'h79 for 3 cycles, then blank → digit_mask stays 0. Repeat with 5 cycles → digit_mask=8'h01.
- Invalid glyph: anodes=8'hFB, segments=7'h7F held for 10 cycles → exactly one seg_err pulse and digit_mask[2]=0. Multi-anode case: anodes=8'hFC → exactly one anode_err pulse.
- Reverse scan with all-F digits: scan 7→0 with glyph 0E on every digit → hex_out=32'hFFFFFFFF. Then apply reset mid-scan after 4 digits → digit_mask=0, hex_out=0, and the next full scan yields a correct word.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// seg7_scan_decoder - rebuilds the hex word from a multiplexed 7-seg scan bus
// Revision: 1.0
// ============================================================================
module seg7_scan_decoder #(
    parameter int SETTLE_CYCLES = 4,
    parameter int DIGITS        = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [6:0]            segments,
    input  logic [DIGITS-1:0]     anodes,
    output logic [4*DIGITS-1:0]   hex_out,
    output logic                  hex_valid,
    output logic [DIGITS-1:0]     digit_mask,
    output logic                  seg_err,
    output logic                  anode_err
);

    localparam int                c_word_w     = 4 * DIGITS;
    localparam int                c_pair_w     = DIGITS + 7;
    localparam logic [7:0]        c_settle_max = 8'(SETTLE_CYCLES - 1);
    localparam logic [DIGITS-1:0] c_all        = '1;
    localparam logic [DIGITS-1:0] c_one        = DIGITS'(1);

    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [c_pair_w-1:0] prev_q, prev_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                done_q, done_d;
    logic [c_word_w-1:0] digits_q, digits_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic [c_word_w-1:0] hex_out_q, hex_out_d;
    logic                hex_valid_q, hex_valid_d;
    logic                seg_err_q, seg_err_d;
    logic                anode_err_q, anode_err_d;

    logic                changed, done_eff, capture, frame_full;
    logic                blank, single, glyph_ok;
    logic [DIGITS-1:0]   an_low;
    logic [3:0]          nibble;

    always_comb begin
        glyph_ok = 1'b1;
        nibble   = 4'h0;
        case (seg_q)
            7'h40: nibble = 4'h0;
            7'h79: nibble = 4'h1;
            7'h24: nibble = 4'h2;
            7'h30: nibble = 4'h3;
            7'h19: nibble = 4'h4;
            7'h12: nibble = 4'h5;
            7'h02: nibble = 4'h6;
            7'h78: nibble = 4'h7;
            7'h00: nibble = 4'h8;
            7'h10: nibble = 4'h9;
            7'h08: nibble = 4'hA;
            7'h03: nibble = 4'hB;
            7'h46: nibble = 4'hC;
            7'h21: nibble = 4'hD;
            7'h06: nibble = 4'hE;
            7'h0E: nibble = 4'hF;
            default: glyph_ok = 1'b0;
        endcase
    end

    always_comb begin
        an_low = ~an_q;
        blank  = (an_low == '0);
        single = !blank && ((an_low & (an_low - c_one)) == '0);

        seg_d   = segments;
        an_d    = anodes;
        prev_d  = {an_q, seg_q};
        changed = (prev_q != {an_q, seg_q});

        // Counter and done flag look at the value this cycle will commit,
        // so SETTLE_CYCLES=1 captures a new pair on its first registered cycle.
        cnt_d    = changed ? 8'd0 : ((cnt_q == c_settle_max) ? cnt_q : cnt_q + 8'd1);
        done_eff = changed ? 1'b0 : done_q;
        capture  = (cnt_d == c_settle_max) && !done_eff;
        done_d   = done_eff | capture;

        frame_full  = (mask_q == c_all);
        mask_d      = frame_full ? '0 : mask_q;
        digits_d    = digits_q;
        seg_err_d   = 1'b0;
        anode_err_d = 1'b0;

        if (capture && !blank) begin
            if (!single) begin
                anode_err_d = 1'b1;
            end else if (!glyph_ok) begin
                seg_err_d = 1'b1;
            end else begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (an_low[i]) begin
                        digits_d[4*i +: 4] = nibble;
                        mask_d[i]          = 1'b1;
                    end
                end
            end
        end

        hex_valid_d = frame_full;
        hex_out_d   = frame_full ? digits_q : hex_out_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            seg_q       <= '0;
            // Cleared anode register means no digit selected, so nothing
            // is captured before real pin values arrive.
            an_q        <= '1;
            prev_q      <= {c_all, 7'h00};
            cnt_q       <= '0;
            done_q      <= 1'b0;
            digits_q    <= '0;
            mask_q      <= '0;
            hex_out_q   <= '0;
            hex_valid_q <= 1'b0;
            seg_err_q   <= 1'b0;
            anode_err_q <= 1'b0;
        end else begin
            seg_q       <= seg_d;
            an_q        <= an_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            digits_q    <= digits_d;
            mask_q      <= mask_d;
            hex_out_q   <= hex_out_d;
            hex_valid_q <= hex_valid_d;
            seg_err_q   <= seg_err_d;
            anode_err_q <= anode_err_d;
        end
    end

    assign hex_out    = hex_out_q;
    assign hex_valid  = hex_valid_q;
    assign digit_mask = mask_q;
    assign seg_err    = seg_err_q;
    assign anode_err  = anode_err_q;

endmodule
`default_nettype wire
